// File: rtl/pkt_framer_pkg.sv
// Shared types and constants for the packet stream framer: state encoding,
// frame word constants, header layout and the payload length rule.
package pkt_framer_pkg;

   localparam int          WORD_W        = 18;
   localparam logic [17:0] SYNC_WORD_DFLT = 18'h2A5C3;

   // HDR layout: {seq[10:0], mem_sel[6:0]}
   localparam int HDR_SEL_W   = 7;
   localparam int HDR_SEQ_W   = 11;
   localparam int HDR_SEQ_LSB = HDR_SEL_W;

   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_SYNC    = 5'b00010,
      ST_HDR     = 5'b00100,
      ST_PAYLOAD = 5'b01000,
      ST_CSUM    = 5'b10000
   } state_t;

   function automatic logic [11:0] eff_len(input logic [11:0] len);
      return (len == 12'd0) ? 12'd1 : len;
   endfunction

   function automatic logic [17:0] make_hdr(input logic [10:0] seq, input logic [6:0] sel);
      return {seq, sel};
   endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 18b wide, depth 2**AW.
// Pointers carry one extra wrap bit so full/empty come from the MSB compare.
module pkt_sync_fifo #(
   parameter int AW = 6
) (
   input  logic        clk_200m,
   input  logic        rstn_200m,
   input  logic        flush,
   input  logic        wr_en,
   input  logic [17:0] wdata,
   input  logic        rd_en,
   output logic [17:0] rdata,
   output logic        full,
   output logic        empty
);

   logic [17:0] mem_q [2**AW];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_wr_s, do_rd_s;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointers; a full FIFO still takes a write when the head pops in the same cycle
   always_comb begin
      do_wr_s = wr_en && !flush && (!full || rd_en);
      do_rd_s = rd_en && !flush && !empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr_s};
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd_s};
      end
   end

   // Pointer registers
   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array
   always_ff @(posedge clk_200m) begin
      if (do_wr_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/pkt_stream_framer.sv
// Buffers capture sample pairs and emits SYNC/HDR/payload/CSUM frames on a
// ready/valid stream toward the host-link serializer.
module pkt_stream_framer
   import pkt_framer_pkg::*;
#(
   parameter int          FIFO_AW   = 6,
   parameter logic [17:0] SYNC_WORD = SYNC_WORD_DFLT
) (
   input  logic        clk_200m,
   input  logic        rstn_200m,
   input  logic [17:0] pkt_data,
   input  logic        pkt_data_valid,
   input  logic        rf_frame_en,
   input  logic [11:0] rf_payload_len,
   input  logic [6:0]  rf_mem_sel,
   input  logic        rf_flush,
   input  logic        rf_ovf_clr,
   output logic [17:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic        st_overflow,
   output logic [15:0] st_frame_cnt
);

   state_t      state_q, state_d;
   logic [17:0] tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        tx_sof_q, tx_sof_d;
   logic        tx_eof_q, tx_eof_d;
   logic [11:0] len_q, len_d;
   logic [6:0]  sel_q, sel_d;
   logic [11:0] cnt_q, cnt_d;
   logic [17:0] csum_q, csum_d;
   logic [10:0] seq_q, seq_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        ovf_q, ovf_d;

   logic [17:0] fifo_rdata_s;
   logic        fifo_full_s, fifo_empty_s, fifo_rd_s;
   logic        accept_s, ovf_set_s;

   pkt_sync_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk_200m  (clk_200m),
      .rstn_200m (rstn_200m),
      .flush     (rf_flush),
      .wr_en     (pkt_data_valid),
      .wdata     (pkt_data),
      .rd_en     (fifo_rd_s),
      .rdata     (fifo_rdata_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign accept_s  = tx_valid_q && tx_ready;
   assign ovf_set_s = pkt_data_valid && !rf_flush && fifo_full_s && !fifo_rd_s;

   // Frame sequencing; the output register always holds the word being offered
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      tx_sof_d    = tx_sof_q;
      tx_eof_d    = tx_eof_q;
      len_d       = len_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      fifo_rd_s   = 1'b0;
      ovf_d       = ovf_set_s ? 1'b1 : (rf_ovf_clr ? 1'b0 : ovf_q);

      case (state_q)
         ST_IDLE: begin
            if (rf_frame_en && !fifo_empty_s) begin
               state_d    = ST_SYNC;
               len_d      = eff_len(rf_payload_len);
               sel_d      = rf_mem_sel;
               cnt_d      = 12'd0;
               tx_data_d  = SYNC_WORD;
               tx_valid_d = 1'b1;
               tx_sof_d   = 1'b1;
               tx_eof_d   = 1'b0;
            end else begin
               tx_valid_d = 1'b0;
               tx_sof_d   = 1'b0;
               tx_eof_d   = 1'b0;
            end
         end
         ST_SYNC: begin
            if (accept_s) begin
               state_d   = ST_HDR;
               tx_data_d = make_hdr(seq_q, sel_q);
               tx_sof_d  = 1'b0;
            end else begin
               state_d = ST_SYNC;
            end
         end
         ST_HDR: begin
            if (accept_s) begin
               state_d    = ST_PAYLOAD;
               tx_data_d  = fifo_rdata_s;
               tx_valid_d = !fifo_empty_s;
               fifo_rd_s  = !fifo_empty_s;
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_PAYLOAD: begin
            if (accept_s) begin
               cnt_d  = cnt_q + 12'd1;
               csum_d = csum_q + tx_data_q;
            end else begin
               cnt_d = cnt_q;
            end
            if (accept_s && ((cnt_q + 12'd1) == len_q)) begin
               state_d    = ST_CSUM;
               tx_data_d  = csum_q + tx_data_q;
               tx_valid_d = 1'b1;
               tx_eof_d   = 1'b1;
            end else if (accept_s || !tx_valid_q) begin
               // refill from the FIFO head; an empty FIFO is the only legal valid gap
               tx_data_d  = fifo_rdata_s;
               tx_valid_d = !fifo_empty_s;
               fifo_rd_s  = !fifo_empty_s;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_CSUM: begin
            if (accept_s) begin
               state_d     = ST_IDLE;
               tx_valid_d  = 1'b0;
               tx_eof_d    = 1'b0;
               csum_d      = 18'd0;
               cnt_d       = 12'd0;
               seq_d       = seq_q + 11'd1;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               state_d = ST_CSUM;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_sof_d   = 1'b0;
            tx_eof_d   = 1'b0;
         end
      endcase

      if (rf_flush) begin
         state_d    = ST_IDLE;
         tx_valid_d = 1'b0;
         tx_sof_d   = 1'b0;
         tx_eof_d   = 1'b0;
         csum_d     = 18'd0;
         cnt_d      = 12'd0;
         fifo_rd_s  = 1'b0;
      end else begin
         fifo_rd_s = fifo_rd_s;
      end
   end

   // State, output and status registers
   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= 18'd0;
         tx_valid_q  <= 1'b0;
         tx_sof_q    <= 1'b0;
         tx_eof_q    <= 1'b0;
         len_q       <= 12'd1;
         sel_q       <= 7'd0;
         cnt_q       <= 12'd0;
         csum_q      <= 18'd0;
         seq_q       <= 11'd0;
         frame_cnt_q <= 16'd0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_sof_q    <= tx_sof_d;
         tx_eof_q    <= tx_eof_d;
         len_q       <= len_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign tx_sof       = tx_sof_q;
   assign tx_eof       = tx_eof_q;
   assign st_overflow  = ovf_q;
   assign st_frame_cnt = frame_cnt_q;

endmodule
